// File: rtl/sync_debounce.sv
// Synchronizer plus counter-based debounce FSM producing a clean level and rise/fall strobes.
// Optional rejected-bounce counter enabled by defining SYNC_DEBOUNCE_GLITCH_CNT_EN.
module sync_debounce #(
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       d_async,
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
   input  logic       clr_glitch,
   output logic [7:0] glitch_cnt,
`endif
   output logic       q,
   output logic       rise,
   output logic       fall
);

   localparam int CNT_W = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam bit SINGLE = (DB_CYCLES == 1);

   typedef enum logic [1:0] {STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO} state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   abort;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= STABLE_LO;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // cnt counts consecutive samples of s that disagree with the accepted level.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      abort   = 1'b0;
      unique case (state_q)
         STABLE_LO: begin
            cnt_d = '0;
            if (s) begin
               if (SINGLE) begin
                  state_d = STABLE_HI;
                  level_d = 1'b1;
                  rise_d  = 1'b1;
               end else begin
                  state_d = CHECK_HI;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         CHECK_HI: begin
            if (!s) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
               abort   = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_HI;
               level_d = 1'b1;
               rise_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         STABLE_HI: begin
            cnt_d = '0;
            if (!s) begin
               if (SINGLE) begin
                  state_d = STABLE_LO;
                  level_d = 1'b0;
                  fall_d  = 1'b1;
               end else begin
                  state_d = CHECK_LO;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         CHECK_LO: begin
            if (s) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
               abort   = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_LO;
               level_d = 1'b0;
               fall_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = STABLE_LO;
            cnt_d   = '0;
            level_d = 1'b0;
         end
      endcase
   end

   assign q    = level_q;
   assign rise = rise_q;
   assign fall = fall_q;

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
   logic [7:0] glitch_cnt_q;

   // Clear takes priority over a simultaneous abort; the count sticks at 8'hFF.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         glitch_cnt_q <= 8'd0;
      end else if (clr_glitch) begin
         glitch_cnt_q <= 8'd0;
      end else if (abort && (glitch_cnt_q != 8'hFF)) begin
         glitch_cnt_q <= glitch_cnt_q + 8'd1;
      end
   end

   assign glitch_cnt = glitch_cnt_q;
`else
   logic unused_abort;
   assign unused_abort = abort;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// Bench for sync_debounce: two instances (DB_CYCLES 4 and 2) checked every cycle against a
// sliding-window reference model, plus directed latency, bounce, reset and saturation steps.
module tb_sync_debounce;

   localparam int DB_A = 4;
   localparam int DB_B = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic d_a = 1'b0, d_b = 1'b0;
   logic clr_a = 1'b0, clr_b = 1'b0;
   logic q_a, rise_a, fall_a;
   logic q_b, rise_b, fall_b;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
   logic [7:0] gc_a, gc_b;
`endif

   int tests = 0;
   int fails = 0;
   int rise_cnt_a = 0;
   int r0;

   // Reference model state: captured-input pipe, window of recent s samples (index 0 newest).
   bit dq [2][2];
   bit win [2][8];
   bit m_q [2];
   bit m_rise [2];
   bit m_fall [2];
   int m_gc [2];

   always #5 clk = ~clk;

   sync_debounce #(.SYNC_STAGES(2), .DB_CYCLES(DB_A)) dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .d_async    (d_a),
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
      .clr_glitch (clr_a),
      .glitch_cnt (gc_a),
`endif
      .q          (q_a),
      .rise       (rise_a),
      .fall       (fall_a)
   );

   sync_debounce #(.SYNC_STAGES(2), .DB_CYCLES(DB_B)) dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .d_async    (d_b),
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
      .clr_glitch (clr_b),
      .glitch_cnt (gc_b),
`endif
      .q          (q_b),
      .rise       (rise_b),
      .fall       (fall_b)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Level flips once the last DB samples of s all disagree with it; a glitch is a
   // disagreeing run that ends with s returning to the current level.
   task automatic model_edge(input int i, input bit rst, input bit d, input bit clr);
      bit s, prev, flip, glitch;
      int db;
      db = (i == 0) ? DB_A : DB_B;
      if (!rst) begin
         dq[i][0] = 1'b0;
         dq[i][1] = 1'b0;
         for (int k = 0; k < 8; k++) win[i][k] = 1'b0;
         m_q[i] = 1'b0;
         m_rise[i] = 1'b0;
         m_fall[i] = 1'b0;
         m_gc[i] = 0;
         return;
      end
      s = dq[i][0];
      dq[i][0] = dq[i][1];
      dq[i][1] = d;
      prev = win[i][0];
      for (int k = 7; k > 0; k--) win[i][k] = win[i][k-1];
      win[i][0] = s;
      flip = 1'b1;
      for (int k = 0; k < db; k++) if (win[i][k] == m_q[i]) flip = 1'b0;
      glitch = !flip && (s == m_q[i]) && (prev != m_q[i]);
      m_rise[i] = flip && !m_q[i];
      m_fall[i] = flip && m_q[i];
      if (flip) m_q[i] = !m_q[i];
      if (clr) m_gc[i] = 0;
      else if (glitch && m_gc[i] < 255) m_gc[i]++;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge(0, rst_n, d_a, clr_a);
      model_edge(1, rst_n, d_b, clr_b);
      #1;
      if (rise_a === 1'b1) rise_cnt_a++;
      chk("a_q", q_a, m_q[0]);
      chk("a_rise", rise_a, m_rise[0]);
      chk("a_fall", fall_a, m_fall[0]);
      chk("b_q", q_b, m_q[1]);
      chk("b_rise", rise_b, m_rise[1]);
      chk("b_fall", fall_b, m_fall[1]);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
      chk("a_gc", gc_a, 8'(m_gc[0]));
      chk("b_gc", gc_b, 8'(m_gc[1]));
`endif
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      int hold_a, hold_b;

      // Reset held with input high
      rst_n = 1'b0; d_a = 1'b1; d_b = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rst_q", q_a, 8'd0);
         chk("rst_rise", rise_a, 8'd0);
         chk("rst_fall", fall_a, 8'd0);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
         chk("rst_gc", gc_a, 8'd0);
`endif
      end
      rst_n = 1'b1; d_a = 1'b0; d_b = 1'b0;
      ticks(8);

      // Clean rising then falling step
      d_a = 1'b1;
      ticks(5);
      chk("step_q_e5", q_a, 8'd0);
      tick();
      chk("step_q_e6", q_a, 8'd1);
      chk("step_rise_e6", rise_a, 8'd1);
      tick();
      chk("step_rise_e7", rise_a, 8'd0);
      ticks(4);
      d_a = 1'b0;
      ticks(5);
      chk("fall_q_e5", q_a, 8'd1);
      tick();
      chk("fall_fall_e6", fall_a, 8'd1);
      chk("fall_q_e6", q_a, 8'd0);
      tick();
      chk("fall_fall_e7", fall_a, 8'd0);

      // Short glitch of three cycles
      clr_a = 1'b1; tick(); clr_a = 1'b0;
      r0 = rise_cnt_a;
      d_a = 1'b1; ticks(3);
      d_a = 1'b0; ticks(8);
      chk("glitch_q", q_a, 8'd0);
      chk("glitch_rises", 8'(rise_cnt_a - r0), 8'd0);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
      chk("glitch_gc", gc_a, 8'd1);
`endif

      // Bounce train then hold high
      clr_a = 1'b1; tick(); clr_a = 1'b0;
      r0 = rise_cnt_a;
      d_a = 1'b1; tick();
      d_a = 1'b0; tick();
      d_a = 1'b1; tick();
      d_a = 1'b0; tick();
      d_a = 1'b1;
      ticks(5);
      chk("bounce_q_e5", q_a, 8'd0);
      tick();
      chk("bounce_q_e6", q_a, 8'd1);
      chk("bounce_rise_e6", rise_a, 8'd1);
      ticks(4);
      chk("bounce_rises", 8'(rise_cnt_a - r0), 8'd1);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
      chk("bounce_gc", gc_a, 8'd2);
`endif
      d_a = 1'b0;
      ticks(10);

      // Reset during a pending rising check
      r0 = rise_cnt_a;
      d_a = 1'b1;
      ticks(3);
      rst_n = 1'b0;
      tick();
      chk("rstmid_q", q_a, 8'd0);
      chk("rstmid_rise", rise_a, 8'd0);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
      chk("rstmid_gc", gc_a, 8'd0);
`endif
      rst_n = 1'b1;
      ticks(5);
      chk("rstrel_q_e5", q_a, 8'd0);
      chk("rstrel_rises", 8'(rise_cnt_a - r0), 8'd0);
      tick();
      chk("rstrel_q_e6", q_a, 8'd1);
      chk("rstrel_rise_e6", rise_a, 8'd1);
      d_a = 1'b0;
      ticks(8);

      // Randomised bursts of varying hold lengths on both instances
      hold_a = 0;
      hold_b = 0;
      for (int n = 0; n < 600; n++) begin
         if (hold_a == 0) begin
            d_a = 1'($urandom_range(0, 1));
            hold_a = $urandom_range(1, 7);
         end
         if (hold_b == 0) begin
            d_b = 1'($urandom_range(0, 1));
            hold_b = $urandom_range(1, 4);
         end
         hold_a--;
         hold_b--;
         clr_a = ($urandom_range(0, 15) == 0);
         clr_b = ($urandom_range(0, 15) == 0);
         tick();
      end
      clr_a = 1'b0; clr_b = 1'b0;
      d_a = 1'b0; d_b = 1'b0;
      ticks(10);

      // Saturation on the DB_CYCLES=2 instance, then clear colliding with an abort
      clr_b = 1'b1; tick(); clr_b = 1'b0;
      for (int n = 0; n < 300; n++) begin
         d_b = 1'b1; tick();
         d_b = 1'b0; tick();
      end
      chk("sat_q", q_b, 8'd0);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
      chk("sat_gc", gc_b, 8'hFF);
`endif
      d_b = 1'b1; tick();
      d_b = 1'b0; clr_b = 1'b1; tick();
      clr_b = 1'b0;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
      chk("clr_abort_gc", gc_b, 8'd0);
`endif
      ticks(6);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sync_debounce.md
# sync_debounce

Front-end conditioning stage for asynchronous board inputs (push-buttons, rider-present and limit switches) on the Segway control board. It samples a raw input through a flop synchronizer chain, then filters contact bounce with a counter-based state machine. It drives a clean registered level plus single-cycle rise and fall strobes into the downstream registered control logic.

## Interface
Parameters:
- SYNC_STAGES, 2: number of synchronizer flops; legal range is 2 or more.
- DB_CYCLES, 16: number of consecutive sampled cycles a new level must hold before it is accepted; legal range is 1 or more.
- CNT_W, derived as $clog2(DB_CYCLES+1): width of the debounce counter. This is a localparam, not a user parameter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the clk rising edge.
- d_async  in  1  raw asynchronous input.
- q  out  1  debounced level, registered.
- rise  out  1  one-cycle strobe when q goes 0 to 1, registered.
- fall  out  1  one-cycle strobe when q goes 1 to 0, registered.
- glitch_cnt  out  8  count of rejected bounces, saturating. Present only with SYNC_DEBOUNCE_GLITCH_CNT_EN.
- clr_glitch  in  1  synchronous clear of glitch_cnt. Present only with SYNC_DEBOUNCE_GLITCH_CNT_EN.

## Operation
Synchronizer:
- Shift chain ff[0..SYNC_STAGES-1], with ff[0] fed by d_async.
- s = ff[SYNC_STAGES-1]. The FSM looks only at s.

FSM states: STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO. cnt is the number of consecutive cycles that s has differed from q.
- STABLE_LO, s=0: stay, cnt=0.
- STABLE_LO, s=1, DB_CYCLES=1: go to STABLE_HI; set q=1, rise=1.
- STABLE_LO, s=1, DB_CYCLES>1: go to CHECK_HI with cnt=1.
- CHECK_HI, s=0: abort to STABLE_LO; cnt=0; record a glitch.
- CHECK_HI, s=1, cnt<DB_CYCLES-1: cnt+1.
- CHECK_HI, s=1, cnt=DB_CYCLES-1: go to STABLE_HI; q=1, rise=1, cnt=0.
- STABLE_HI and CHECK_LO mirror the above with the polarity inverted, fall in place of rise, and a glitch recorded on abort.

Outputs:
- rise and fall are high for exactly one cycle per accepted transition. They are never both high in the same cycle.
- q changes only on the same edge that raises rise or fall.

Arithmetic:
- cnt never exceeds DB_CYCLES-1. No wrap-around is possible.
- glitch_cnt saturates at 8'hFF and never wraps.

Reset (rst_n=0 at an edge):
- All synchronizer flops go to 0.
- State goes to STABLE_LO, cnt=0, q=0, rise=0, fall=0, glitch_cnt=0.
- Reset asserted while in a CHECK state discards the pending transition. No strobe and no glitch is recorded.

## Timing
- Latency, counting the edge that first captures the new d_async value into ff[0] as edge 1: q, rise and fall update on edge SYNC_STAGES+DB_CYCLES.
- With the defaults this is edge 18.
- A pulse on s shorter than DB_CYCLES cycles never reaches q.
- A held level causes exactly one transition.
- d_async changing every cycle keeps the FSM alternating between STABLE and CHECK. q holds its value and a glitch is recorded on every abort.
- An abort and clr_glitch in the same cycle: the clear wins and glitch_cnt = 0.
- First cycle after rst_n deasserts: the FSM evaluates s from the reset-cleared chain. A d_async already at 1 before reset release is accepted after the normal latency, counted from the first post-reset capture edge.

## Configuration
- Macro SYNC_DEBOUNCE_GLITCH_CNT_EN.
- Defined: the glitch_cnt and clr_glitch ports and the 8-bit saturating counter exist. Each abort from CHECK_HI or CHECK_LO increments it by 1.
- Undefined: those ports and the counter are absent. FSM behaviour, q, rise and fall are identical in both builds.

## Test plan
All scenarios use SYNC_STAGES=2 and DB_CYCLES=4 unless stated.
- Reset: hold rst_n=0 for 3 edges with d_async=1 -> q=0, rise=0, fall=0, glitch_cnt=0 throughout.
- Clean step: d_async goes 0 to 1 and holds -> q=1 and rise=1 on edge 6, rise=0 on edge 7. The 1 to 0 step then gives fall on edge 6 of that step.
- Short glitch: d_async high for 3 cycles then low -> q stays 0, no strobes, glitch_cnt=1.
- Bounce train: d_async toggles 1,0,1,0,1 on single cycles, then holds 1 -> q=1 exactly 6 edges after the final rise, exactly one rise pulse, glitch_cnt=2.
- Reset mid-check: d_async=1, then rst_n=0 on edge 4 -> q=0, no rise. After release with d_async still 1, q=1 on edge 6 after release.
- Saturation and clear, DB_CYCLES=2: 300 two-cycle-period glitches -> glitch_cnt=255. Then clr_glitch asserted in the same cycle as an abort -> glitch_cnt=0 on the next cycle.
